// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-NCH stream demultiplexer.
// Each output channel has its own one-entry holding register, so a stalled
// consumer only blocks words addressed to its own channel.
// Optional build macro DEMUX_STREAM_CNT_EN adds per-channel 8-bit drain
// counters on output port xfer_cnt (bits [k*8 +: 8] for channel k).
module demux_stream #(
    parameter int unsigned DW  = 4,
    parameter int unsigned NCH = 8,
    parameter int unsigned SW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [SW-1:0]     sel,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*DW-1:0] out_data,
    output logic              sel_err
`ifdef DEMUX_STREAM_CNT_EN
    ,
    output logic [NCH*8-1:0]  xfer_cnt
`endif
);

    localparam int unsigned CW = 8;

    logic [NCH-1:0]    sel_hit_c;
    logic [NCH-1:0]    slot_free_c;
    logic [NCH-1:0]    fill_c;
    logic [NCH-1:0]    drain_c;
    logic              accept_c;
    logic              sel_oor_c;

    logic [NCH-1:0]    valid_q, valid_d;
    logic [NCH*DW-1:0] data_q, data_d;
    logic              sel_err_q, sel_err_d;

    // One-hot decode of the select; all-zero when sel addresses no channel.
    always_comb begin
        sel_hit_c = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            sel_hit_c[k] = (sel == SW'(k));
        end
    end

    // Handshake: a channel slot is free when empty or being drained this cycle.
    // Out-of-range selects hit no channel and are always accepted (discarded).
    always_comb begin
        slot_free_c = ~valid_q | out_ready;
        in_ready    = ~|(sel_hit_c & ~slot_free_c);
        accept_c    = in_valid & in_ready;
        sel_oor_c   = ~|sel_hit_c;
        fill_c      = sel_hit_c & {NCH{accept_c}};
        drain_c     = valid_q & out_ready;
    end

    // Next state of the holding registers and the sticky select-error flag.
    always_comb begin
        valid_d   = (valid_q & ~drain_c) | fill_c;
        data_d    = data_q;
        sel_err_d = sel_err_q | (accept_c & sel_oor_c);
        for (int unsigned k = 0; k < NCH; k++) begin
            if (fill_c[k]) begin
                data_d[k*DW +: DW] = in_data;
            end
        end
    end

    // Holding register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            data_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Outputs come straight from the registers.
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign sel_err   = sel_err_q;

`ifdef DEMUX_STREAM_CNT_EN
    logic [NCH*CW-1:0] cnt_q, cnt_d;

    // Per-channel drain counters, wrapping naturally at 255.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned k = 0; k < NCH; k++) begin
            cnt_d[k*CW +: CW] = cnt_q[k*CW +: CW] + CW'(drain_c[k]);
        end
    end

    // Counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: two instances (NCH=8 and NCH=5).
// Stimulus pushes expected words per channel; a negedge monitor pops and
// compares whenever a channel of the NCH=8 instance is drained.
module tb_demux_stream;

    logic        clk;
    logic        rst;

    // Instance A: NCH=8, SW=3
    logic        in_valid_a;
    logic        in_ready_a;
    logic [3:0]  in_data_a;
    logic [2:0]  sel_a;
    logic [7:0]  out_valid_a;
    logic [7:0]  out_ready_a;
    logic [31:0] out_data_a;
    logic        sel_err_a;

    // Instance B: NCH=5, SW=3
    logic        in_valid_b;
    logic        in_ready_b;
    logic [3:0]  in_data_b;
    logic [2:0]  sel_b;
    logic [4:0]  out_valid_b;
    logic [4:0]  out_ready_b;
    logic [19:0] out_data_b;
    logic        sel_err_b;

`ifdef DEMUX_STREAM_CNT_EN
    logic [63:0] xfer_cnt_a;
    logic [39:0] xfer_cnt_b;
`endif

    demux_stream #(.DW(4), .NCH(8), .SW(3)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_data   (in_data_a),
        .sel       (sel_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_data  (out_data_a),
        .sel_err   (sel_err_a)
`ifdef DEMUX_STREAM_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt_a)
`endif
    );

    demux_stream #(.DW(4), .NCH(5), .SW(3)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .sel       (sel_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b),
        .sel_err   (sel_err_b)
`ifdef DEMUX_STREAM_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt_b)
`endif
    );

    typedef struct packed {
        int         ch;
        logic [3:0] d;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a word to instance A; wait (bounded) for in_ready, record it, clock it in.
    task automatic send(input int ch, input logic [3:0] d, input bit strict);
        int  n;
        sb_t e;
        n          = 0;
        sel_a      = 3'(ch);
        in_data_a  = d;
        in_valid_a = 1'b1;
        #1;
        if (strict) check("in_ready_no_stall", 64'(in_ready_a), 64'd1);
        while (!in_ready_a && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready_a) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ch %0d got in_ready 0 expected 1", ch);
        end else begin
            e.ch = ch;
            e.d  = d;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid_a = 1'b0;
    endtask

    // Reset pulse between clock edges; the expected queue is discarded with it.
    task automatic reset_pulse();
        #1 rst = 1'b1;
        #1;
        sb.delete();
        rst = 1'b0;
    endtask

    // Monitor: every drain on instance A must match the oldest word queued for that channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                if (out_valid_a[k] && out_ready_a[k]) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (idx < 0 && sb[i].ch == k) idx = i;
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL drain_ch%0d: got %0h expected no word", k, out_data_a[k*4 +: 4]);
                    end else begin
                        if (out_data_a[k*4 +: 4] !== sb[idx].d) begin
                            errors++;
                            $display("FAIL drain_ch%0d: got %0h expected %0h", k, out_data_a[k*4 +: 4], sb[idx].d);
                        end
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_valid_a  = 1'b0;
        in_data_a   = '0;
        sel_a       = '0;
        out_ready_a = '0;
        in_valid_b  = 1'b0;
        in_data_b   = '0;
        sel_b       = '0;
        out_ready_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_out_valid", 64'(out_valid_a), 64'h0);
        check("rst_out_data", 64'(out_data_a), 64'h0);
        check("rst_sel_err", 64'(sel_err_a), 64'h0);
        check("rst_in_ready", 64'(in_ready_a), 64'h1);

        // Reset mid-stream: ch2 loaded then async reset without an edge
        send(2, 4'hA, 1'b1);
        check("fill_ch2_valid", 64'(out_valid_a), 64'h04);
        check("fill_ch2_data", 64'(out_data_a), 64'h0000_0A00);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid_a), 64'h0);
        check("async_rst_data", 64'(out_data_a), 64'h0);
        check("async_rst_sel_err", 64'(sel_err_a), 64'h0);
        sb.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic routing
        send(3, 4'h5, 1'b1);
        check("route_valid", 64'(out_valid_a), 64'h08);
        check("route_data", 64'(out_data_a), 64'h0000_5000);

        // Backpressure isolation
        sel_a      = 3'd3;
        in_data_a  = 4'h9;
        in_valid_a = 1'b1;
        #1;
        check("bp_in_ready_ch3", 64'(in_ready_a), 64'h0);
        @(posedge clk);
        #1;
        check("bp_hold_valid", 64'(out_valid_a), 64'h08);
        check("bp_hold_data", 64'(out_data_a), 64'h0000_5000);
        in_valid_a = 1'b0;
        send(6, 4'hC, 1'b1);
        check("bp_other_valid", 64'(out_valid_a), 64'h48);
        check("bp_other_data", 64'(out_data_a), 64'h0C00_5000);

        // Multi-channel drain in one cycle, data retained afterwards
        out_ready_a = 8'hFF;
        @(posedge clk);
        #1;
        out_ready_a = 8'h00;
        check("drain_valid", 64'(out_valid_a), 64'h00);
        check("drain_retain", 64'(out_data_a), 64'h0C00_5000);

        // Same-cycle drain and fill on ch1
        send(1, 4'h1, 1'b1);
        out_ready_a = 8'h02;
        send(1, 4'h2, 1'b1);
        check("dfill_valid", 64'(out_valid_a), 64'h02);
        check("dfill_data", 64'(out_data_a), 64'h0C00_5020);

        // Back-to-back stream into ch1
        for (int i = 0; i < 10; i++) send(1, 4'(i + 3), 1'b1);
        @(posedge clk);
        #1;
        out_ready_a = 8'h00;
        check("stream_valid", 64'(out_valid_a), 64'h00);
        check("stream_data", 64'(out_data_a), 64'h0C00_50C0);
        check("sb_empty_a", 64'(sb.size()), 64'h0);
        check("sel_err_a_clear", 64'(sel_err_a), 64'h0);

        // Out-of-range select on NCH=5 instance
        sel_b      = 3'd6;
        in_data_b  = 4'h7;
        in_valid_b = 1'b1;
        #1;
        check("oor_in_ready", 64'(in_ready_b), 64'h1);
        check("oor_sel_err_before", 64'(sel_err_b), 64'h0);
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        check("oor_sel_err", 64'(sel_err_b), 64'h1);
        check("oor_valid", 64'(out_valid_b), 64'h00);
        check("oor_data", 64'(out_data_b), 64'h0);
        repeat (3) @(posedge clk);
        #1;
        check("oor_sel_err_held", 64'(sel_err_b), 64'h1);
        sel_b      = 3'd4;
        in_data_b  = 4'h3;
        in_valid_b = 1'b1;
        #1;
        check("top_ch_in_ready", 64'(in_ready_b), 64'h1);
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        check("top_ch_valid", 64'(out_valid_b), 64'h10);
        check("top_ch_data", 64'(out_data_b), 64'h3_0000);
        check("oor_sel_err_still", 64'(sel_err_b), 64'h1);
        reset_pulse();
        check("oor_sel_err_rst", 64'(sel_err_b), 64'h0);
        check("oor_valid_rst", 64'(out_valid_b), 64'h00);
        @(posedge clk);
        #1;

`ifdef DEMUX_STREAM_CNT_EN
        // 257 drains on ch0 wrap its counter to 1
        out_ready_a = 8'h01;
        for (int i = 0; i < 257; i++) send(0, 4'(i), 1'b1);
        @(posedge clk);
        #1;
        out_ready_a = 8'h00;
        check("cnt_wrap", xfer_cnt_a, 64'h1);
        check("cnt_valid_empty", 64'(out_valid_a), 64'h00);
`endif

        check("sb_empty_end", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Parametrised, registered 1-to-NCH demultiplexer with a valid/ready handshake on the input and on every output channel.
- Routes each input word to the output channel chosen by `sel`.
- Each channel has a one-entry holding register, so one stalled consumer does not block words bound for other channels.
- Sits between a single producer (e.g. switch/keypad decoder or bus master) and NCH downstream consumers such as display digits or LED banks.

Parameters:
- DW, 4: data width per word/channel.
- NCH, 8: number of output channels; 2 <= NCH <= 2**SW.
- SW, 3: width of the select input.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block can accept the word this cycle.
- in_data  input  DW  input word.
- sel  input  SW  destination channel index, sampled with in_data.
- out_valid  output  NCH  bit k: channel k holds a word.
- out_ready  input  NCH  bit k: consumer k takes its word this cycle.
- out_data  output  NCH*DW  channel k word in bits [k*DW +: DW].
- sel_err  output  1  sticky flag: a word with sel >= NCH was accepted.

Behaviour:
- Reset (async, active-high):
  - out_valid = 0, out_data = 0, sel_err = 0.
  - in_ready follows its combinational equation once rst deasserts.
  - A transfer in flight when rst asserts is lost.
- Free slot: slot_free[k] = !out_valid[k] || out_ready[k].
- in_ready (combinational): slot_free[sel] when sel < NCH; 1 when sel >= NCH.
  - in_ready does not depend on in_valid.
- Input accept: in_valid && in_ready at a rising edge.
- Latency: an accepted word appears on out_data[sel] with out_valid[sel] = 1 on the next cycle (1-cycle latency).
- Output drain: out_valid[k] && out_ready[k] at an edge. out_valid[k] clears next cycle unless the same edge also refills channel k.
- Simultaneous drain and fill of channel k: out_valid[k] stays 1 and out_data[k] takes the new word. Full throughput of 1 word/cycle per channel.
- Other channels are never affected by a transfer on channel k. Multiple channels may drain in the same cycle.
- Only one channel can be filled per cycle (single input).
- Data retention:
  - out_data[k] changes only on a fill of channel k.
  - After a drain, out_data[k] keeps its last value while out_valid[k] = 0.
- Backpressure:
  - Channel k full and out_ready[k] = 0 with sel = k: in_ready = 0, and the producer must hold in_data/sel stable.
  - The producer may change sel while in_valid = 0.
- Out-of-range sel (sel >= NCH, only possible when NCH < 2**SW):
  - The word is accepted and discarded; no out_valid changes.
  - sel_err sets on the next cycle and stays set until rst.
- No combinational path from in_valid to any output. The only combinational path is out_ready/sel to in_ready.

Optional Feature:
- Macro: DEMUX_STREAM_CNT_EN.
- When defined, extra output port `xfer_cnt`, output, NCH*8 bits:
  - One 8-bit counter per channel, in bits [k*8 +: 8].
  - Counter k increments on each out_valid[k] && out_ready[k] drain.
  - Counters wrap 255 -> 0.
  - Reset value 0.
- When undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream: fill ch2 with 4'hA, assert rst for one cycle without an edge -> out_valid = 8'h00, out_data = 0, sel_err = 0 immediately.
- Basic routing: in_data = 4'h5, sel = 3, in_valid = 1 for one cycle, all out_ready = 0 -> next cycle out_valid = 8'h08 and out_data[3] = 4'h5; other channels' data unchanged.
- Backpressure isolation:
  - With ch3 full and out_ready[3] = 0, present sel = 3 -> in_ready = 0.
  - Switch to sel = 6, data 4'hC -> in_ready = 1, and next cycle out_valid = 8'h48.
- Same-cycle drain/fill: ch1 holds 4'h1, out_ready[1] = 1, input 4'h2 to sel = 1 -> out_valid[1] stays 1, out_data[1] = 4'h2. Stream 10 words back-to-back at 1 word/cycle with no stall.
- Out-of-range select: NCH = 5, SW = 3, send 4'h7 with sel = 6 -> in_ready = 1, out_valid unchanged, sel_err = 1 from the next cycle and held until rst.
- With DEMUX_STREAM_CNT_EN: 257 drains on ch0 -> xfer_cnt[7:0] = 1; the other counters stay 0.
